// File: rtl/pattern_sequencer.sv
// ============================================================================
//  Module      : pattern_sequencer
//  Description : Detects rising edges of the divided step clock and advances
//                an LED pattern (rotate-left/right, bounce, binary count).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic [1:0]       mode,
    input  logic             run,
    output logic [WIDTH-1:0] leds,
    output logic             dir,
    output logic             step_pulse,
    output logic             wrap
);

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_BNC = 2'b10;
    localparam logic [1:0] MODE_CNT = 2'b11;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_cur_mode;
    logic             w_step;
    logic [WIDTH-1:0] w_next_leds;
    logic             w_next_dir;
    logic             w_wrap;

    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        logic [WIDTH-1:0] s;
        case (m)
            MODE_ROR: s = {1'b1, {(WIDTH-1){1'b0}}};
            MODE_CNT: s = '0;
            default:  s = WIDTH'(1);
        endcase
        return s;
    endfunction

    assign w_step = r_s2 & ~r_s3 & run;

    always_comb begin
        w_next_leds = leds;
        w_next_dir  = dir;
        w_wrap      = 1'b0;
        if (mode != r_cur_mode) begin
            w_next_leds = seed_of(mode);
            w_next_dir  = 1'b0;
        end else if ((r_cur_mode != MODE_CNT) && (leds == '0)) begin
            // A lost one-hot pattern is recovered by reseeding, never flagged as a wrap
            w_next_leds = seed_of(r_cur_mode);
            w_next_dir  = 1'b0;
        end else begin
            case (r_cur_mode)
                MODE_ROL: begin
                    w_next_leds = {leds[WIDTH-2:0], leds[WIDTH-1]};
                    w_wrap      = (w_next_leds == seed_of(MODE_ROL));
                end
                MODE_ROR: begin
                    w_next_leds = {leds[0], leds[WIDTH-1:1]};
                    w_wrap      = (w_next_leds == seed_of(MODE_ROR));
                end
                MODE_BNC: begin
                    if (!dir) begin
                        w_next_leds = {leds[WIDTH-2:0], 1'b0};
                        if (w_next_leds[WIDTH-1]) w_next_dir = 1'b1;
                    end else begin
                        w_next_leds = {1'b0, leds[WIDTH-1:1]};
                        if (w_next_leds[0]) begin
                            w_next_dir = 1'b0;
                            w_wrap     = (w_next_leds == seed_of(MODE_BNC));
                        end
                    end
                end
                default: begin
                    w_next_leds = leds + WIDTH'(1);
                    w_wrap      = (w_next_leds == seed_of(MODE_CNT));
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_cur_mode <= MODE_ROL;
            leds       <= WIDTH'(1);
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            r_s1       <= step_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            step_pulse <= w_step;
            wrap       <= w_step & w_wrap;
            if (w_step) begin
                r_cur_mode <= mode;
                leds       <= w_next_leds;
                dir        <= w_next_dir;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
// ============================================================================
//  Module      : tb_pattern_sequencer
//  Description : Self-checking bench for pattern_sequencer against a
//                phase-counter reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         step_in = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         run = 1'b1;
    logic [W-1:0] leds;
    logic         dir;
    logic         step_pulse;
    logic         wrap;

    int n_cmp = 0;
    int n_err = 0;
    int wrap_seen = 0;

    // Reference model: the pattern is a pure function of (mode, phase)
    int m_cm = 0;
    int m_ph = 0;
    bit m_wrap = 1'b0;

    pattern_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_in    (step_in),
        .mode       (mode),
        .run        (run),
        .leds       (leds),
        .dir        (dir),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_period(input int cm);
        case (cm)
            0, 1:    return W;
            2:       return 2 * W - 2;
            default: return 1 << W;
        endcase
    endfunction

    function automatic logic [W-1:0] m_leds();
        int pos;
        int v;
        case (m_cm)
            0: v = 1 << m_ph;
            1: v = 1 << (W - 1 - m_ph);
            2: begin
                pos = (m_ph < W) ? m_ph : (2 * W - 2 - m_ph);
                v = 1 << pos;
            end
            default: v = m_ph;
        endcase
        return W'(v);
    endfunction

    function automatic logic m_dir();
        return (m_cm == 2) && (m_ph >= W - 1);
    endfunction

    task automatic m_step(input int m);
        if (m != m_cm) begin
            m_cm   = m;
            m_ph   = 0;
            m_wrap = 1'b0;
        end else begin
            m_ph   = (m_ph + 1) % m_period(m_cm);
            m_wrap = (m_ph == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_cm = 0;
        m_ph = 0;
        @(posedge clk);
        #1;
        check_eq("rst_leds", leds, 32'h01);
        check_eq("rst_dir", dir, 0);
        check_eq("rst_pulse", step_pulse, 0);
        check_eq("rst_wrap", wrap, 0);
    endtask

    // Called at 1 ns after a rising edge; one full step_in pulse
    task automatic pulse(input logic [1:0] m, input logic r, input int hi, input int lo, input bit late);
        mode = m;
        run  = r;
        if (late) #8;
        step_in = 1'b1;
        @(posedge clk); #1;
        check_eq("k_leds", leds, m_leds());
        check_eq("k_pulse", step_pulse, 0);
        @(posedge clk); #1;
        check_eq("k1_leds", leds, m_leds());
        check_eq("k1_pulse", step_pulse, 0);
        if (r) m_step(int'(m));
        @(posedge clk); #1;
        check_eq("k2_leds", leds, m_leds());
        check_eq("k2_dir", dir, m_dir());
        check_eq("k2_pulse", step_pulse, r);
        check_eq("k2_wrap", wrap, r & m_wrap);
        if (wrap) wrap_seen++;
        @(posedge clk); #1;
        check_eq("k3_pulse", step_pulse, 0);
        check_eq("k3_wrap", wrap, 0);
        for (int i = 4; i < hi; i++) begin
            @(posedge clk); #1;
            check_eq("hold_leds", leds, m_leds());
            check_eq("hold_pulse", step_pulse, 0);
        end
        step_in = 1'b0;
        for (int i = 0; i < lo; i++) begin
            @(posedge clk); #1;
            check_eq("low_pulse", step_pulse, 0);
        end
    endtask

    initial begin
        logic [1:0] rm;
        do_reset();

        for (int i = 0; i < 8; i++) pulse(2'b00, 1'b1, 4, 3, 1'b0);
        check_eq("rol_end", leds, 32'h01);

        do_reset();
        for (int i = 0; i < 15; i++) pulse(2'b10, 1'b1, 4, 3, 1'b0);
        check_eq("bnc_end", leds, 32'h01);
        check_eq("bnc_dir", dir, 0);

        wrap_seen = 0;
        for (int i = 0; i < 257; i++) pulse(2'b11, 1'b1, 4, 3, 1'b0);
        check_eq("cnt_end", leds, 32'h00);
        check_eq("cnt_wraps", wrap_seen, 1);

        for (int i = 0; i < 5; i++) pulse((i < 2) ? 2'b11 : 2'b01, 1'b0, 4, 3, 1'b0);
        pulse(2'b01, 1'b1, 4, 3, 1'b0);
        check_eq("pause_ror", leds, 32'h80);

        pulse(2'b01, 1'b1, 100, 4, 1'b1);
        check_eq("long_hi", leds, 32'h40);

        rm = 2'b00;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) rm = 2'($urandom_range(0, 3));
            pulse(rm, ($urandom_range(0, 7) != 0), int'($urandom_range(4, 8)),
                  int'($urandom_range(3, 6)), ($urandom_range(0, 1) == 1));
        end

        do_reset();
        for (int i = 0; i < 10; i++) pulse(2'b10, 1'b1, 4, 3, 1'b0);
        check_eq("pre_rst_leds", leds, 32'h20);
        check_eq("pre_rst_dir", dir, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_leds", leds, 32'h01);
        check_eq("async_dir", dir, 0);
        check_eq("async_pulse", step_pulse, 0);
        @(negedge clk);
        rst = 1'b0;
        m_cm = 0;
        m_ph = 0;
        @(posedge clk); #1;
        pulse(2'b00, 1'b1, 4, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pattern_sequencer.md
# pattern_sequencer

Downstream consumer of the slow divided clock in the pattern displayer. Samples the divider's square-wave output in the fast `clk` domain and detects its rising edges. On each detected edge it advances a WIDTH-bit LED pattern according to the selected mode: rotate-left, rotate-right, bounce, or binary count. It drives the board LEDs directly and flags each step and each pattern wrap.

## Interface
- `WIDTH`, default 16: number of LEDs / pattern bits; legal range 4..32.
- `clk`, input, 1: system clock, the same clock that drives the divider.
- `rst`, input, 1: reset, asynchronous, active-high.
- `step_in`, input, 1: divided clock level from the divider; treated as asynchronous and not used as a clock.
- `mode`, input, 2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary up-count.
- `run`, input, 1: 1 means steps advance the pattern; 0 means the pattern is paused.
- `leds`, output, WIDTH: current pattern, registered.
- `dir`, output, 1: bounce direction; 0 means moving toward the MSB, 1 means moving toward the LSB. Registered.
- `step_pulse`, output, 1: one-cycle pulse, high in the cycle after `leds` was updated by a step.
- `wrap`, output, 1: one-cycle pulse, coincident with `step_pulse`, when the step returned the pattern to its seed.

## Operation
- Synchronizer: `step_in` passes through flops s1, s2, s3; a rise is detected when `s2 & ~s3`. All three flops reset to 0.
  - If `step_in` is already high when `rst` releases, exactly one step is detected. This is accepted behaviour.
- A step is a detected rise while `run`=1. A rise while `run`=0 is discarded and is not queued.
- Internal register `cur_mode`, 2 bits.
- Seeds per mode:
  - 00: bit0 set only.
  - 01: bit WIDTH-1 set only.
  - 10: bit0 set only.
  - 11: all zeros.
- On a step with `mode` != `cur_mode`:
  - `cur_mode` <= `mode`; `leds` <= seed(`mode`); `dir` <= 0.
  - `step_pulse` is asserted; `wrap` is not.
- On a step with `mode` == `cur_mode`, advance the pattern:
  - 00: rotate left by 1; MSB goes to bit0.
  - 01: rotate right by 1; bit0 goes to MSB.
  - 10, `dir`=0: shift left by 1; if the result has bit WIDTH-1 set, `dir` <= 1.
  - 10, `dir`=1: shift right by 1; if the result has bit0 set, `dir` <= 0.
  - 11: `leds` + 1, modulo 2^WIDTH.
- `wrap` rule: asserted when the advanced result equals seed(`cur_mode`).
  - In bounce mode, `wrap` is asserted only on the `dir` 1->0 turn. The bounce period is 2*(WIDTH-1) steps.
- Recovery: in modes 00, 01 and 10, if `leds` == 0 at a step, load the seed instead of advancing, with no `wrap`.
- A `mode` change while `run`=0 takes effect on the first step after `run` returns to 1.
- `mode` is sampled only on steps; changes between steps have no effect.

## Timing
- Reset values: `leds` = 1 (bit0 only), `cur_mode` = 00, `dir` = 0, `step_pulse` = 0, `wrap` = 0, s1..s3 = 0.
- `rst` acts immediately and asynchronously, regardless of `clk`.
- Step latency: `step_in` high at clk edge k is captured in s1 at k. The rise is detected in the cycle after edge k+1. `leds`/`dir` update at edge k+2. `step_pulse`/`wrap` are high from edge k+2 to edge k+3.
- At most one step per `step_in` rising edge, regardless of how long `step_in` stays high.
- Minimum `step_in` high and low time: 3 clk cycles. Shorter pulses may be missed.
- `run` and `mode` are sampled at edge k+2, the same edge as the update.
- `step_pulse` and `wrap` never exceed one cycle. Consecutive steps are at least 6 cycles apart.

## Test plan
- WIDTH=8, mode=00, `run`=1, 8 steps after reset -> `leds` 02,04,08,10,20,40,80,01. `wrap` only on the 8th step. `step_pulse` on all 8.
- Reset, mode=10, 15 steps -> 1st step loads 01 with no `wrap`. Then 02..80, with `dir`=1 set on the step to 80. Then 40..01, with `wrap` and `dir`=0 on the 15th step.
- mode=11, 257 steps -> 1st step loads 00. `leds` counts 01..FF and back to 00 on step 257, with exactly one `wrap`.
- `run`=0 for 5 `step_in` edges -> `leds` is held and `step_pulse` stays 0. Change `mode` to 01 while paused, then `run`=1 and one step -> `leds`=80, no `wrap`.
- `step_in` rises 1 ns before edge k and is held high for 100 cycles -> `leds` changes exactly once, at edge k+2; `step_pulse` is high for one cycle only.
- Bounce with `leds`=20, `dir`=1; assert `rst` between clock edges -> `leds`=01, `dir`=0, `step_pulse`=0 immediately, before the next `clk` edge.
